comp2_serial_driver: RTL and testbench

- Bit-serial word driver and collector for the serial two's-complement FSM.
- Accepts a parallel WIDTH-bit word and issues a one-cycle clear to the FSM.
- Shifts the word out LSB-first and samples the FSM's Mealy output bit in the same cycle.
- Reassembles the returned bits into a parallel result with a one-cycle done pulse, so the complementer can be used as a word-level negation unit.

---
 rtl/comp2_serial_driver.sv | 99 +++++++++
 tb/tb_comp2_serial_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/comp2_serial_driver.sv
// comp2_serial_driver
// Parallel-to-serial driver and serial-to-parallel collector for the bit-serial
// two's-complement FSM. A word is loaded, the FSM is cleared for one cycle,
// the word is shifted out LSB-first while the FSM's Mealy response is shifted
// into an accumulator, and the rebuilt word is presented with a done pulse.
// Looped through the complementer this behaves as a word-level negation unit.

module comp2_serial_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             ser_clr,
  output logic             ser_out,
  input  logic             ser_in,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  // Frame sequencing: IDLE -> CLR -> SHIFT (WIDTH cycles) -> DONE -> IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Counter value seen on the edge that takes the final bit of the frame
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;

  // State register: a start is only honoured in IDLE, so requests made
  // while a frame is in flight are dropped rather than queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= CLR;
        CLR:     state <= SHIFT;
        SHIFT:   if (cnt == LAST_BIT) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: shreg feeds the FSM LSB-first while the returned bits enter acc
  // from the top, so after WIDTH shifts bit i of the response sits in acc[i]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= data_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          acc   <= {ser_in, acc[WIDTH-1:1]};
          shreg <= shreg >> 1;
          cnt   <= cnt + CNT_ONE;
        end
        DONE: begin
          result_q <= acc;
        end
        default: begin
          shreg <= shreg;
        end
      endcase
    end
  end

  // Output decode; in DONE the result bypasses result_q so it is valid in the
  // same cycle as the done pulse, and ser_out is forced low outside SHIFT so
  // the FSM never sees stray data during clear or idle
  always_comb begin
    busy    = (state != IDLE);
    ser_clr = (state == CLR);
    ser_out = (state == SHIFT) && shreg[0];
    done    = (state == DONE);
    result  = (state == DONE) ? acc : result_q;
  end

endmodule

// File: tb/tb_comp2_serial_driver.sv
// tb_comp2_serial_driver
// Drives comp2_serial_driver against a behavioural two's-complement responder
// (or a plain wire loopback) and checks every cycle against a frame-level model
// plus a result scoreboard popped on each done pulse.

module tb_comp2_serial_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         busy, ser_clr, ser_out, ser_in, done;
  logic [W-1:0] result;

  logic         wire_mode = 1'b0;
  logic         seen_one;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] sb[$];

  // frame-level model state
  bit           m_active = 1'b0;
  int           m_k = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_exp_cur = '0;
  logic [W-1:0] m_last = '0;

  always #5 clk = ~clk;

  comp2_serial_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .busy(busy), .ser_clr(ser_clr), .ser_out(ser_out), .ser_in(ser_in),
    .result(result), .done(done)
  );

  // serial complementer: copy bits up to and including the first 1, invert after
  always @(posedge clk or negedge rst) begin
    if (!rst)         seen_one <= 1'b0;
    else if (ser_clr) seen_one <= 1'b0;
    else if (ser_out) seen_one <= 1'b1;
  end

  assign ser_in = wire_mode ? ser_out : (ser_out ^ seen_one);

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] d, input logic wm);
    logic [W-1:0] zero;
    zero = '0;
    return wm ? d : (zero - d);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame model: one CLR cycle, W shift cycles, one DONE cycle, then idle
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_active = 1'b0;
        m_k = 0;
        m_exp_cur = '0;
        m_last = '0;
        sb.delete();
      end else if (m_active) begin
        if (m_k == W + 1) begin
          m_active = 1'b0;
          m_last = m_exp_cur;
        end else begin
          m_k++;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k = 0;
        m_data = data_in;
        m_exp_cur = ref_word(data_in, wire_mode);
        sb.push_back(m_exp_cur);
      end
    end
  end

  // monitor: per-cycle control/result check and scoreboard pop on done
  initial begin
    logic [3:0]   exp_ctrl;
    logic         exp_so;
    logic [W-1:0] exp_res;
    logic [W-1:0] popped;
    forever begin
      @(negedge clk);
      exp_so = (m_active && m_k >= 1 && m_k <= W) ? m_data[m_k-1] : 1'b0;
      exp_ctrl = {m_active, m_active && (m_k == 0), exp_so, m_active && (m_k == W + 1)};
      exp_res = (m_active && m_k == W + 1) ? m_exp_cur : m_last;
      checkOutput("ctrl{busy,clr,so,done}", {28'd0, busy, ser_clr, ser_out, done}, {28'd0, exp_ctrl});
      checkOutput("result_hold", {24'd0, result}, {24'd0, exp_res});
      if (done === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL sb_pop: done with empty scoreboard, result %0h", result);
        end else begin
          popped = sb.pop_front();
          if (result !== popped) begin
            fails++;
            $display("[TB] FAIL sb_result: got %0h expected %0h", result, popped);
          end
        end
      end
    end
  end

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!m_active && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] d);
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    data_in = W'($urandom);
    waitIdle();
  endtask

  logic [W-1:0] vin [5]  = '{8'h0C, 8'h00, 8'h01, 8'h80, 8'hFF};
  logic [W-1:0] vout [5] = '{8'hF4, 8'h00, 8'hFF, 8'h80, 8'h01};

  initial begin
    logic [W-1:0] r0;
    logic [W-1:0] d;
    bit reached;

    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {28'd0, busy, ser_clr, ser_out, done}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);
    rst = 1'b1;

    // idle with start low
    r0 = result;
    repeat (20) @(negedge clk);
    checkOutput("idle_result", {24'd0, result}, {24'd0, r0});

    // directed operands through the complementer
    wire_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vin[i]);
      checkOutput("directed_neg", {24'd0, result}, {24'd0, vout[i]});
    end

    // bit ordering with a plain wire
    wire_mode = 1'b1;
    applyStimulus(8'hA5);
    checkOutput("wire_loop", {24'd0, result}, 32'h0000_00A5);
    wire_mode = 1'b0;

    // start held high, with start/data_in disturbed in mid-frame
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (m_active && m_k >= 2 && m_k <= W - 1) begin
        start = 1'($urandom);
        data_in = W'($urandom);
      end else begin
        start = 1'b1;
        data_in = 8'h03;
      end
    end
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("held_start", {24'd0, result}, 32'h0000_00FD);

    // randomized words in both loop modes
    for (int i = 0; i < 20; i++) begin
      wire_mode = 1'($urandom);
      d = W'($urandom);
      applyStimulus(d);
      checkOutput("random_word", {24'd0, result}, {24'd0, ref_word(d, wire_mode)});
    end
    wire_mode = 1'b0;

    // asynchronous reset during SHIFT bit 4
    @(negedge clk);
    start = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_active && m_k == 5) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("reach_bit4", {31'd0, reached}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_ctrl", {28'd0, busy, ser_clr, ser_out, done}, 32'd0);
    checkOutput("async_rst_result", {24'd0, result}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_result", {24'd0, result}, 32'd0);
    applyStimulus(8'h02);
    checkOutput("after_rst_word", {24'd0, result}, 32'h0000_00FE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
